// File: rtl/regfile_mp.sv
// regfile_mp: parametrised N-read / 2-write register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to make same-cycle writes visible on the read ports.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int ZERO_REG = 1,
    parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h10008000),
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h7FFFEFFC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_cnt;

    logic              w_wr0_ok;
    logic              w_wr1_ok;
    logic              w_set_ok;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // wr0 is dropped outright when wr1 targets the same entry
    assign w_wr1_ok = wr1_en && !is_zero(wr1_addr);
    assign w_wr0_ok = wr0_en && !is_zero(wr0_addr)
                      && !(wr1_en && (wr1_addr == wr0_addr));
    assign w_set_ok = sb_set_en && !is_zero(sb_set_addr);

    // a new producer supersedes a retiring one, so set is applied last
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0_ok) w_busy_nxt[wr0_addr] = 1'b0;
        if (w_wr1_ok) w_busy_nxt[wr1_addr] = 1'b0;
        if (w_set_ok) w_busy_nxt[sb_set_addr] = 1'b1;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ADDR_W >= 5 && i == 28)
                    r_mem[i] <= GP_INIT;
                else if (ADDR_W >= 5 && i == 29)
                    r_mem[i] <= SP_INIT;
                else
                    r_mem[i] <= '0;
            end
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
            if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_cnt;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_bsy;

        assign w_ra = rd_addr[g*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = r_mem[w_ra];
            w_bsy  = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_wr1_ok && (wr1_addr == w_ra)) begin
                w_data = wr1_data;
                w_bsy  = w_set_ok && (sb_set_addr == w_ra);
            end else if (w_wr0_ok && (wr0_addr == w_ra)) begin
                w_data = wr0_data;
                w_bsy  = w_set_ok && (sb_set_addr == w_ra);
            end
`endif
            if (is_zero(w_ra)) begin
                w_data = '0;
                w_bsy  = 1'b0;
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = w_data;
        assign rd_busy[g] = w_bsy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + randomized checks of regfile_mp against an array model.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en = 1'b0;
    logic [4:0]  wr0_addr = '0;
    logic [31:0] wr0_data = '0;
    logic        wr1_en = 1'b0;
    logic [4:0]  wr1_addr = '0;
    logic [31:0] wr1_data = '0;
    logic        sb_set_en = 1'b0;
    logic [4:0]  sb_set_addr = '0;
    logic [5:0]  busy_cnt;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_mem [32];
    bit          m_busy [32];

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))
            return sb_set_en && sb_set_addr == a;
`endif
        return m_busy[a];
    endfunction

    // model state update from the inputs held across this edge
    function automatic void commit();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_mem[28] = 32'h10008000;
            m_mem[29] = 32'h7FFFEFFC;
            return;
        end
        if (wr0_en && wr0_addr != 0) begin
            m_mem[wr0_addr] = wr0_data;
            m_busy[wr0_addr] = 1'b0;
        end
        if (wr1_en && wr1_addr != 0) begin
            m_mem[wr1_addr] = wr1_data;
            m_busy[wr1_addr] = 1'b0;
        end
        if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        sb_set_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [4] = '{5'd0, 5'd28, 5'd29, 5'd5};
        logic [31:0] exps  [4] = '{32'h0, 32'h10008000, 32'h7FFFEFFC, 32'h0};
        idle();
        rst = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            rd_addr = {5'd0, addrs[i]};
            #1;
            n_total++;
            if (rd_data[31:0] !== exps[i])
                $display("FAIL reset_data a=%0d got %h exp %h", addrs[i], rd_data[31:0], exps[i]);
            else n_pass++;
            n_total++;
            if (rd_busy[0] !== 1'b0)
                $display("FAIL reset_busy a=%0d got %b exp 0", addrs[i], rd_busy[0]);
            else n_pass++;
        end
        n_total++;
        if (busy_cnt !== 6'd0)
            $display("FAIL reset_cnt got %0d exp 0", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_dual_write();
        wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'hAAAA0000;
        wr1_en = 1'b1; wr1_addr = 5'd8; wr1_data = 32'h5555FFFF;
        tick();
        idle();
        rd_addr = {5'd0, 5'd8};
        #1;
        n_total++;
        if (rd_data[31:0] !== 32'h5555FFFF)
            $display("FAIL dual_same got %h exp 5555ffff", rd_data[31:0]);
        else n_pass++;
        wr0_en = 1'b1; wr0_addr = 5'd9;  wr0_data = 32'h11112222;
        wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'h33334444;
        tick();
        idle();
        rd_addr = {5'd10, 5'd9};
        #1;
        n_total++;
        if (rd_data[31:0] !== 32'h11112222)
            $display("FAIL dual_diff_wr0 got %h exp 11112222", rd_data[31:0]);
        else n_pass++;
        n_total++;
        if (rd_data[63:32] !== 32'h33334444)
            $display("FAIL dual_diff_wr1 got %h exp 33334444", rd_data[63:32]);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hDEADBEEF;
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        tick();
        idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        n_total++;
        if (rd_data[31:0] !== 32'h0)
            $display("FAIL zero_data got %h exp 0", rd_data[31:0]);
        else n_pass++;
        n_total++;
        if (rd_busy[0] !== 1'b0)
            $display("FAIL zero_busy got %b exp 0", rd_busy[0]);
        else n_pass++;
        n_total++;
        if (busy_cnt !== 6'd0)
            $display("FAIL zero_cnt got %0d exp 0", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        for (int k = 4; k <= 6; k++) begin
            sb_set_en = 1'b1; sb_set_addr = 5'(k);
            tick();
            idle();
            n_total++;
            if (busy_cnt !== 6'(k - 3))
                $display("FAIL sb_set_cnt k=%0d got %0d exp %0d", k, busy_cnt, k - 3);
            else n_pass++;
        end
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h00000055;
        tick();
        idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        n_total++;
        if (busy_cnt !== 6'd2)
            $display("FAIL sb_clr_cnt got %0d exp 2", busy_cnt);
        else n_pass++;
        n_total++;
        if (rd_busy[0] !== 1'b0)
            $display("FAIL sb_clr_busy got %b exp 0", rd_busy[0]);
        else n_pass++;
        sb_set_en = 1'b1; sb_set_addr = 5'd4;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h00000044;
        tick();
        idle();
        rd_addr = {5'd0, 5'd4};
        #1;
        n_total++;
        if (rd_busy[0] !== 1'b1)
            $display("FAIL sb_setwins_busy got %b exp 1", rd_busy[0]);
        else n_pass++;
        n_total++;
        if (busy_cnt !== 6'd2)
            $display("FAIL sb_setwins_cnt got %0d exp 2", busy_cnt);
        else n_pass++;
        n_total++;
        if (rd_data[31:0] !== 32'h00000044)
            $display("FAIL sb_setwins_data got %h exp 00000044", rd_data[31:0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        tick();
        idle();
        n_total++;
        if (busy_cnt !== 6'd3)
            $display("FAIL mid_pre_cnt got %0d exp 3", busy_cnt);
        else n_pass++;
        rst = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h00001234;
        sb_set_en = 1'b1; sb_set_addr = 5'd13;
        tick();
        idle();
        rd_addr = {5'd0, 5'd12};
        #1;
        n_total++;
        if (busy_cnt !== 6'd0)
            $display("FAIL mid_cnt got %0d exp 0", busy_cnt);
        else n_pass++;
        n_total++;
        if (rd_data[31:0] !== 32'h0)
            $display("FAIL mid_data got %h exp 0", rd_data[31:0]);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [31:0] e_now;
`ifdef REGFILE_BYPASS_EN
        e_now = 32'hCAFEF00D;
`else
        e_now = 32'h0;
`endif
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hCAFEF00D;
        rd_addr = {5'd7, 5'd3};
        #1;
        n_total++;
        if (rd_data[63:32] !== e_now)
            $display("FAIL bypass_same got %h exp %h", rd_data[63:32], e_now);
        else n_pass++;
        n_total++;
        if (rd_busy[1] !== 1'b0)
            $display("FAIL bypass_busy got %b exp 0", rd_busy[1]);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (rd_data[63:32] !== 32'hCAFEF00D)
            $display("FAIL bypass_next got %h exp cafef00d", rd_data[63:32]);
        else n_pass++;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        logic [4:0] a;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 59) == 0);
            wr0_en = $urandom_range(0, 1) == 1;
            wr0_addr = rnd_addr();
            wr0_data = $urandom;
            wr1_en = $urandom_range(0, 2) == 0;
            wr1_addr = rnd_addr();
            wr1_data = $urandom;
            sb_set_en = $urandom_range(0, 1) == 1;
            sb_set_addr = rnd_addr();
            rd_addr = {rnd_addr(), rnd_addr()};
            #1;
            for (int p = 0; p < 2; p++) begin
                a = rd_addr[p*5 +: 5];
                n_total++;
                if (rd_data[p*32 +: 32] !== exp_rd(a))
                    $display("FAIL rnd_data cyc=%0d p=%0d a=%0d got %h exp %h",
                             cyc, p, a, rd_data[p*32 +: 32], exp_rd(a));
                else n_pass++;
                n_total++;
                if (rd_busy[p] !== exp_busy(a))
                    $display("FAIL rnd_busy cyc=%0d p=%0d a=%0d got %b exp %b",
                             cyc, p, a, rd_busy[p], exp_busy(a));
                else n_pass++;
            end
            n_total++;
            if (busy_cnt !== 6'(m_cnt()))
                $display("FAIL rnd_cnt cyc=%0d got %0d exp %0d", cyc, busy_cnt, m_cnt());
            else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        #2;
        test_reset();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the MIPS cores. It is the successor to the single-cycle 2R/1W register file. It adds the following:
- configurable data width, depth and read-port count
- two write ports with fixed priority
- a per-register busy scoreboard for multi-cycle producers (loads, mult/div)

It sits between decode (reads) and writeback (writes) and serves both the SINGLE and pipelined datapaths.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
GP_INIT, 32'h10008000, reset value of entry 28 (applied only if ADDR_W >= 5)
SP_INIT, 32'h7FFFEFFC, reset value of entry 29 (applied only if ADDR_W >= 5)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  scoreboard busy bit of each addressed register
wr0_en  in  1  write port 0 enable (ALU writeback)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (memory/multi-cycle writeback)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
sb_set_en  in  1  mark a register busy (producer issued)
sb_set_addr  in  ADDR_W  register to mark busy
busy_cnt  out  ADDR_W+1  number of entries currently busy

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high, sampled only at posedge clk.
- Reset at posedge with rst=1:
  - all entries become 0, except entry 28 = GP_INIT and entry 29 = SP_INIT;
  - all busy bits are cleared and busy_cnt = 0;
  - rst overrides any write or sb_set in the same cycle.
- Reads are combinational, with zero latency from rd_addr to rd_data and rd_busy. Before the first reset, array contents are X; the bench must not rely on them.
- ZERO_REG=1:
  - address 0 always reads 0 with rd_busy = 0;
  - writes and sb_set to address 0 are discarded and never counted in busy_cnt.
- Writes commit at posedge clk; new data is visible on rd_data in the following cycle.
- wr0 and wr1 to the same address in the same cycle: wr1 wins and wr0 is dropped. Different addresses are both written.
- Scoreboard: one busy bit per entry.
  - sb_set_en sets busy[sb_set_addr].
  - A committed write on either port clears busy[wr_addr].
  - sb_set and a write to the same address in the same cycle: set wins, so the bit stays 1 (a new producer supersedes the old one).
  - Setting an already-busy bit is a no-op.
- busy_cnt is registered and always equals the popcount of the busy bits. It updates in the same posedge as the bits, and its range is 0..2**ADDR_W (minus 1 when ZERO_REG=1).
- Address wrap: addresses are taken modulo depth, with no out-of-range handling needed.
- There is no handshake back-pressure. The issuing stage stalls on rd_busy; regfile_mp never blocks writes.

Optional Feature:
Macro: REGFILE_BYPASS_EN

Defined (write-through):
- If a read address matches an enabled write in the same cycle, rd_data returns that write's data combinationally.
- Priority is wr1 > wr0 > array.
- rd_busy for that port is 0 unless sb_set_en targets the same address in that cycle.
- Address 0 is still forced to 0 when ZERO_REG=1.

Undefined:
- Reads see only committed array contents; the new value appears one cycle after the write.
- rd_busy reflects the registered busy bit only.

Test Plan:
1. Reset: drive rst=1 for one edge, then read addresses 0, 28, 29, 5 -> 0, 32'h10008000, 32'h7FFFEFFC, 0; rd_busy=0 and busy_cnt=0.
2. Dual write: wr0 (addr 8, 32'hAAAA0000) and wr1 (addr 8, 32'h5555FFFF) in the same cycle -> next cycle addr 8 reads 32'h5555FFFF. Separately, wr0 to addr 9 and wr1 to addr 10 in one cycle -> both values are stored.
3. Zero register: wr0 to addr 0 with 32'hDEADBEEF, plus sb_set on addr 0 -> addr 0 reads 0, rd_busy=0 and busy_cnt unchanged.
4. Scoreboard:
   - set 4, 5 and 6 over three cycles -> busy_cnt counts 1, 2, 3;
   - wr1 to 5 -> busy_cnt=2 and rd_busy for 5 = 0;
   - same-cycle sb_set(4) and wr0(4) -> busy[4] stays 1 and busy_cnt stays 2.
5. Reset mid-operation: with 3 busy bits set and wr0 (addr 12, 32'h1234) asserted alongside rst=1 -> busy_cnt=0 and addr 12 reads 0.
6. Bypass: wr0 (addr 7, 32'hCAFEF00D) while rd_addr port 1 = 7 -> with REGFILE_BYPASS_EN, port 1 reads 32'hCAFEF00D in the same cycle; without it, port 1 reads the old value (0 after reset) and the new value the next cycle.
